uart_rx_unit: RTL and testbench

Serial receiver between the board Rx pin and the CPU's UART peripheral registers in data memory. It oversamples the asynchronous line and frames 8N1 bytes. It presents each received byte with a valid flag, plus sticky error flags, for the CPU to poll and acknowledge with a read strobe. It is the upstream feeder of the CPU's receive path.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_unit.sv | 136 +++++++++++++
 tb/tb_uart_rx_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversample default and baud divider helper.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

  // Clocks per oversample tick, rounded to nearest and never below 1.
  function automatic int unsigned uart_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned den;
    int unsigned q;
    den = baud * os;
    if (den == 0) return 1;
    q = (clk_hz + den / 2) / den;
    return (q == 0) ? 1 : q;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider emitting a one-cycle tick every DIV clocks; restart re-phases it to zero.
module uart_baud_tick #(
  parameter int unsigned DIV = 651
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver: 2-flop synchroniser, oversampled majority vote, framing FSM,
// and a CPU-facing byte register with valid and sticky error flags.
module uart_rx_unit
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       overrun,
  output logic       frame_err
);

  localparam int unsigned DIV = uart_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned TW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_LO   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_HI   = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

  rx_state_t     state, state_nxt;
  logic          rx_meta, rx_s;
  logic          tick;
  logic [TW-1:0] tcnt;
  logic [1:0]    votes;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          decide_c, bit_val_c;
  logic          restart_c, shift_c, load_c, ferr_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart_c),
    .tick    (tick)
  );

  // Tick index within the bit; preloaded to 1 so index 0 falls on each bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt  <= '0;
      votes <= '0;
    end else if (restart_c) begin
      tcnt <= TW'(1);
    end else if (tick) begin
      tcnt <= (tcnt == T_LAST) ? '0 : tcnt + TW'(1);
      if (tcnt == T_LO)  votes[0] <= rx_s;
      if (tcnt == T_MID) votes[1] <= rx_s;
    end
  end

  assign decide_c  = tick && (tcnt == T_HI);
  assign bit_val_c = (votes[0] & votes[1]) | (votes[0] & rx_s) | (votes[1] & rx_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx <= '0;
      shreg   <= '0;
    end else if (shift_c) begin
      shreg   <= {bit_val_c, shreg[7:1]};
      bit_idx <= bit_idx + 3'd1;
    end else if (restart_c) begin
      bit_idx <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (!rx_s) state_nxt = ST_START;
      ST_START:     if (decide_c) state_nxt = bit_val_c ? ST_IDLE : ST_DATA;
      ST_DATA:      if (decide_c && bit_idx == 3'd7) state_nxt = ST_STOP;
      ST_STOP:      if (decide_c) state_nxt = bit_val_c ? ST_IDLE : ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (rx_s) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Divider is held in IDLE so the first tick after the start edge is phase-aligned.
  always_comb begin
    restart_c = 1'b0;
    shift_c   = 1'b0;
    load_c    = 1'b0;
    ferr_c    = 1'b0;
    case (state)
      ST_IDLE: restart_c = 1'b1;
      ST_DATA: shift_c   = decide_c;
      ST_STOP: begin
        load_c = decide_c & bit_val_c;
        ferr_c = decide_c & ~bit_val_c;
      end
      default: ;
    endcase
  end

  // A read coinciding with a completion keeps the new byte valid and suppresses overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (load_c) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rd) begin
        rx_valid <= 1'b0;
      end
      overrun   <= !rd && (overrun || (load_c && rx_valid));
      frame_err <= ferr_c || (frame_err && !rd);
    end
  end

endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed bench for uart_rx_unit at DIV=10 (160 clks per bit) with a byte scoreboard.
module tb_uart_rx_unit;

  localparam int BIT = 160;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;

  int errors = 0;
  int checks = 0;
  int lat1   = 0;
  int lat    = 0;
  logic [7:0] exp_q[$];

  uart_rx_unit #(
    .CLK_HZ     (1_600_000),
    .BAUD       (10_000),
    .OVERSAMPLE (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rd        (rd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_byte(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(rx_data), 32'(e));
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  // Drives one full frame; rd_at>0 asserts rd so that it is high at that edge count.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input int rd_at, output int lat_o);
    logic [9:0] fr;
    logic       prev;
    fr    = {stop_bit, d, 1'b0};
    lat_o = 0;
    for (int c = 0; c < 10 * BIT; c++) begin
      rx   = fr[c / BIT];
      rd   = (rd_at != 0) && (c + 1 == rd_at);
      prev = rx_valid;
      @(negedge clk);
      if (!prev && rx_valid && lat_o == 0) lat_o = c + 1;
    end
    rd = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    rd  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rx_data",   32'(rx_data),   32'h00);
    chk("reset_rx_valid",  32'(rx_valid),  32'd0);
    chk("reset_overrun",   32'(overrun),   32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    idle(20);

    // 1: clean 0x55
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 0, lat1);
    chk("t1_latency_window", 32'((lat1 >= 1510) && (lat1 <= 1550)), 32'd1);
    check_byte("t1_rx_data");
    chk("t1_rx_valid",  32'(rx_valid),  32'd1);
    chk("t1_overrun",   32'(overrun),   32'd0);
    chk("t1_frame_err", 32'(frame_err), 32'd0);
    pulse_rd();
    chk("t1_rd_clears_valid", 32'(rx_valid), 32'd0);

    // 2: short glitch
    rx = 1'b0;
    repeat (40) @(negedge clk);
    idle(2 * BIT);
    chk("t2_glitch_valid",     32'(rx_valid),  32'd0);
    chk("t2_glitch_frame_err", 32'(frame_err), 32'd0);

    // 3: framing error, break, recovery
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(20);
    send_frame(8'hA3, 1'b0, 0, lat);
    chk("t3_frame_err_set", 32'(frame_err), 32'd1);
    chk("t3_ferr_valid",    32'(rx_valid),  32'd0);
    chk("t3_ferr_data",     32'(rx_data),   32'h00);
    rx = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    idle(BIT);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 0, lat);
    check_byte("t3_rx_data");
    chk("t3_rx_valid",         32'(rx_valid),  32'd1);
    chk("t3_frame_err_sticky", 32'(frame_err), 32'd1);
    pulse_rd();
    chk("t3_rd_frame_err", 32'(frame_err), 32'd0);
    chk("t3_rd_valid",     32'(rx_valid),  32'd0);
    idle(20);

    // 4: back-to-back without rd -> overrun
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 0, lat);
    check_byte("t4_first_data");
    exp_q.push_back(8'h34);
    send_frame(8'h34, 1'b1, 0, lat);
    check_byte("t4_second_data");
    chk("t4_rx_valid", 32'(rx_valid), 32'd1);
    chk("t4_overrun",  32'(overrun),  32'd1);
    pulse_rd();
    chk("t4_rd_valid",     32'(rx_valid),  32'd0);
    chk("t4_rd_overrun",   32'(overrun),   32'd0);
    chk("t4_rd_frame_err", 32'(frame_err), 32'd0);
    idle(20);

    // 5: rd coincides with completion of the second byte
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 0, lat);
    check_byte("t5_first_data");
    exp_q.push_back(8'h34);
    send_frame(8'h34, 1'b1, lat1, lat);
    check_byte("t5_second_data");
    chk("t5_rx_valid", 32'(rx_valid), 32'd1);
    chk("t5_overrun",  32'(overrun),  32'd0);

    // 6: reset during bit 4 of 0xF0, then 0x81
    begin
      logic [9:0] fr;
      fr = {1'b1, 8'hF0, 1'b0};
      for (int c = 0; c < 5 * BIT + BIT / 2; c++) begin
        rx = fr[c / BIT];
        @(negedge clk);
      end
    end
    rst = 1'b1;
    #1;
    chk("t6_rst_rx_data",   32'(rx_data),   32'h00);
    chk("t6_rst_rx_valid",  32'(rx_valid),  32'd0);
    chk("t6_rst_overrun",   32'(overrun),   32'd0);
    chk("t6_rst_frame_err", 32'(frame_err), 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    idle(2 * BIT);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 0, lat);
    check_byte("t6_rx_data");
    chk("t6_rx_valid",  32'(rx_valid),  32'd1);
    chk("t6_overrun",   32'(overrun),   32'd0);
    chk("t6_frame_err", 32'(frame_err), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
